// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port data memory for the calculator datapath.
//
// A valid/ready request port accepts reads and byte-masked writes. Each
// accepted request produces exactly one response RD_LAT edges later. Depth
// need not be a power of two, and addresses >= DEPTH answer with Err.
// After reset, and again whenever Clr is seen, a clear engine zeroes one word
// per cycle. Requests are refused while it runs.
//
// Optional build macro: MEM_STATS_EN adds saturating read/write counters.
//
// Ports:
//   Clk, Reset           clock, asynchronous active-high reset
//   Req_Valid/Req_Ready  request handshake (accept = both high at an edge)
//   R_W, Addr, Din, Be   request fields (1 = write; Be ignored on reads)
//   Clr, Busy            soft-clear request / clear engine running
//   Rsp_Valid, Dout, Err response (Dout/Err are zero when Rsp_Valid is low)
//   Rd_Cnt, Wr_Cnt       accepted in-range read/write counts (MEM_STATS_EN only)

module mem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Req_Valid,
    output logic                Req_Ready,
    input  logic                R_W,
    input  logic [ADDR_W-1:0]   Addr,
    input  logic [DATA_W-1:0]   Din,
    input  logic [DATA_W/8-1:0] Be,
    input  logic                Clr,
    output logic                Busy,
    output logic                Rsp_Valid,
    output logic [DATA_W-1:0]   Dout,
    output logic                Err
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]         Rd_Cnt,
    output logic [15:0]         Wr_Cnt
`endif
);

    localparam int                NB      = DATA_W / 8;
    // One extra bit so that DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, ACTIVE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                accept;
    logic                in_range;
    logic [RD_LAT-1:0]   pipe_valid;
    logic [RD_LAT-1:0]   pipe_err;
    logic [DATA_W-1:0]   pipe_data [RD_LAT];

    assign Req_Ready = (state == ACTIVE) && !Clr;
    assign accept    = Req_Valid && Req_Ready;
    assign in_range  = {1'b0, Addr} < DEPTH_X;

    // Clear engine / mode FSM. Busy is kept as a register alongside the state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= CLEAR;
            cnt   <= '0;
            Busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == LAST) begin
                        state <= ACTIVE;
                        cnt   <= '0;
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (Clr) begin
                        state <= CLEAR;
                        Busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    Busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage array. It has no reset; the clear engine initialises it.
    always_ff @(posedge Clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (accept && R_W && in_range) begin
            for (int k = 0; k < NB; k++) begin
                if (Be[k]) mem[Addr][8*k +: 8] <= Din[8*k +: 8];
            end
        end
    end

    // Response pipeline. Idle slots carry zero data and error, so the
    // outputs read as zero whenever Rsp_Valid is low.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_data[i] <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && !in_range;
            pipe_data[0]  <= (accept && !R_W && in_range) ? mem[Addr] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign Rsp_Valid = pipe_valid[RD_LAT-1];
    assign Err       = pipe_err[RD_LAT-1];
    assign Dout      = pipe_data[RD_LAT-1];

`ifdef MEM_STATS_EN
    // Saturating counters of accepted in-range requests. They are zeroed by
    // reset and whenever Clr starts a clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Rd_Cnt <= '0;
            Wr_Cnt <= '0;
        end else if (state == ACTIVE && Clr) begin
            Rd_Cnt <= '0;
            Wr_Cnt <= '0;
        end else if (accept && in_range) begin
            if (R_W) begin
                if (Wr_Cnt != 16'hFFFF) Wr_Cnt <= Wr_Cnt + 16'd1;
            end else begin
                if (Rd_Cnt != 16'hFFFF) Rd_Cnt <= Rd_Cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Parametrised single-port data memory for the calculator datapath. It is the successor to the flat register-array memory.
- Adds a valid/ready request handshake, per-byte write enables, configurable read latency, a non-power-of-two depth with out-of-range error reporting, and a sequential (one word per cycle) clear engine.
- Sits between the calculator control unit and the storage array. Every accepted request produces exactly one response.

Parameters:
- ADDR_W, 8: address width in bits.
- DATA_W, 32: word width in bits. Must be a multiple of 8.
- DEPTH, 256: number of words. Legal range is 1..2^ADDR_W. Addresses >= DEPTH are illegal.
- RD_LAT, 1: response latency in clock edges. Legal range is 1..4.

Ports:
- Clk, input, 1: clock. All state updates on the rising edge.
- Reset, input, 1: asynchronous, active-high reset.
- Req_Valid, input, 1: request present.
- Req_Ready, output, 1: block can accept a request this cycle.
- R_W, input, 1: 1 = write, 0 = read.
- Addr, input, ADDR_W: word address.
- Din, input, DATA_W: write data.
- Be, input, DATA_W/8: byte write enables. Bit k enables Din[8k+7:8k]. Ignored on reads.
- Clr, input, 1: soft-clear request, level-sampled.
- Busy, output, 1: clear engine running.
- Rsp_Valid, output, 1: response valid. One-cycle pulse per accepted request.
- Dout, output, DATA_W: read data. Zero for writes and for errors.
- Err, output, 1: response is for an out-of-range address. Qualified by Rsp_Valid.

Behaviour:
- FSM states are CLEAR and ACTIVE.
- Reset asserted (async):
  - FSM goes to CLEAR; clear counter goes to 0.
  - Response pipeline is flushed.
  - Outputs: Rsp_Valid=0, Dout=0, Err=0, Busy=1, Req_Ready=0.
- CLEAR state:
  - Each edge writes 0 to mem[cnt] and increments cnt.
  - The edge that writes mem[DEPTH-1] moves the FSM to ACTIVE with cnt=0.
  - Busy=1 for exactly DEPTH cycles after Reset deasserts.
  - Req_Ready=0; Clr is ignored.
- ACTIVE state:
  - Busy=0.
  - Req_Ready = !Clr (combinational).
  - Clr=1 moves the FSM to CLEAR on the next edge. Any request in the same cycle is not accepted.
- Acceptance is the edge where Req_Valid & Req_Ready. Addr, R_W, Din and Be are sampled at that edge.
- Write, Addr < DEPTH: only bytes with Be[k]=1 are updated at the acceptance edge. Be=0 leaves the word unchanged; the response is still generated.
- Read, Addr < DEPTH: mem[Addr] is sampled at the acceptance edge.
- Addr >= DEPTH: no array access; Err=1 and Dout=0 in the response.
- Response timing:
  - The response enters an RD_LAT-stage pipeline.
  - Rsp_Valid, Dout and Err are registered outputs, visible after edge N+RD_LAT-1, where N is the acceptance edge.
  - With RD_LAT=1 they are valid in the cycle directly after acceptance.
  - Rsp_Valid is high for one cycle per request. There is no response backpressure.
  - Back-to-back requests give back-to-back responses, one per cycle, in order.
- Read after write, same address, consecutive accepts: the read returns the newly written data. No bypass is needed, because the write completes at the earlier edge.
- When Rsp_Valid=0, Dout and Err hold 0.
- Responses already in the pipeline when a clear starts still drain normally. Their data was sampled before the clear.
- Reset mid-clear or mid-pipeline: the clear restarts from cnt=0 and in-flight responses are dropped.

Optional Feature:
- Macro MEM_STATS_EN.
- When defined:
  - Adds output Rd_Cnt[15:0] and output Wr_Cnt[15:0].
  - Each counts accepted in-range reads/writes, incremented at the acceptance edge.
  - Counters saturate at 16'hFFFF.
  - Errored requests are not counted.
  - Both counters reset to 0 on Reset and on entry to CLEAR via Clr.
- When undefined: the ports and counter logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset pulse, DEPTH=256 -> Busy=1 and Req_Ready=0 for exactly 256 cycles after deassert. Then a read of addr 0xFF returns Dout=0, Err=0.
- RD_LAT=1: write 0xDEADBEEF to addr 5 (Be=4'hF), then read addr 5 on the next cycle -> Rsp_Valid on two consecutive cycles; second response Dout=0xDEADBEEF.
- Write 0x11223344 (Be=4'b0101) over 0xDEADBEEF at addr 5, then read -> Dout=0xDE22BE44.
- DEPTH=200: read addr 200 and write addr 255 -> both responses have Err=1, Dout=0; a following read of 199 is unaffected.
- RD_LAT=3: four back-to-back reads of addrs 1..4 holding 10..13 -> Rsp_Valid high for 4 consecutive cycles starting 2 cycles after the first accept; Dout=10, 11, 12, 13.
- Clr asserted with Req_Valid=1 in the same cycle -> request not accepted; Busy=1 for DEPTH cycles; a subsequent read returns 0. With MEM_STATS_EN, Rd_Cnt and Wr_Cnt read 0 after the clear.
